// File: rtl/sat_acc_stream.sv
// sat_acc_stream: streaming symmetric-saturating packet accumulator; optional beat count via SAT_ACC_CNT_EN
module sat_acc_stream #(
  parameter int W     = 4,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_sat
`ifdef SAT_ACC_CNT_EN
  ,
  output logic [CNT_W-1:0] out_cnt
`endif
);
  typedef enum logic {ACC, HOLD} state_t;
  localparam logic signed [W:0] MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] MIN = -MAX;
  state_t            state_q;
  logic   [W-1:0]    acc_q, acc_d, out_data_q;
  logic              sat_q, sat_d, out_sat_q, out_valid_q, in_ready_q;
  logic              in_min, fire;
  logic signed [W-1:0] x;
  logic signed [W:0]   sum;
`ifdef SAT_ACC_CNT_EN
  logic   [CNT_W-1:0] cnt_q, cnt_d, out_cnt_q;
  assign cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign out_cnt = out_cnt_q;
`endif
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign fire      = in_valid && in_ready_q;
  // sanitise the operand, add in W+1 bits and clamp to the symmetric range
  always_comb begin
    in_min = in_data == {1'b1, {(W-1){1'b0}}};
    x      = in_min ? MIN[W-1:0] : in_data;
    sum    = {acc_q[W-1], acc_q} + {x[W-1], x};
    acc_d  = (sum > MAX) ? MAX[W-1:0] : (sum < MIN) ? MIN[W-1:0] : sum[W-1:0];
    sat_d  = sat_q | in_min | (sum > MAX) | (sum < MIN);
  end
  // accumulate beats in ACC, present and hold the packet result in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
`ifdef SAT_ACC_CNT_EN
      cnt_q       <= '0;
      out_cnt_q   <= '0;
`endif
    end else if (state_q == ACC) begin
      in_ready_q <= !(fire && in_last);
      if (fire && in_last) begin
        out_data_q  <= acc_d;
        out_sat_q   <= sat_d;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        sat_q       <= 1'b0;
        state_q     <= HOLD;
`ifdef SAT_ACC_CNT_EN
        out_cnt_q   <= cnt_d;
        cnt_q       <= '0;
`endif
      end else if (fire) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
`ifdef SAT_ACC_CNT_EN
        cnt_q <= cnt_d;
`endif
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      state_q     <= ACC;
    end
  end
endmodule

// File: tb/tb_sat_acc_stream.sv
// tb_sat_acc_stream: directed and randomized checks of sat_acc_stream against an arithmetic packet model
module tb_sat_acc_stream;
  localparam int W = 4, CNT_W = 10;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0, out_data;
  logic in_ready, out_valid, out_sat;
`ifdef SAT_ACC_CNT_EN
  logic [CNT_W-1:0] out_cnt;
`endif
  int checks = 0, passed = 0, failed = 0;
  int pkt[$];

  sat_acc_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
`ifdef SAT_ACC_CNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v, input bit last);
    int n = 0;
    if ($urandom_range(0, 3) == 0) tick();
    in_valid = 1'b1;
    in_data  = W'(v);
    in_last  = last;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("in_ready_timeout", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic void model(output int s, output bit sat, output int n);
    s = 0;
    sat = 0;
    foreach (pkt[i]) begin
      int x = pkt[i];
      if (x == -8) begin x = -7; sat = 1; end
      s += x;
      if (s > 7) begin s = 7; sat = 1; end
      else if (s < -7) begin s = -7; sat = 1; end
    end
    n = pkt.size() > 1023 ? 1023 : pkt.size();
  endfunction

  task automatic run_pkt(input string tag, input int stall);
    int s, n;
    bit sat;
    model(s, sat, n);
    out_ready = (stall == 0);
    foreach (pkt[i]) beat(pkt[i], i == pkt.size() - 1);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk({tag, "_data"}, $signed(out_data), s);
    chk({tag, "_sat"}, {31'b0, out_sat}, {31'b0, sat});
`ifdef SAT_ACC_CNT_EN
    chk({tag, "_cnt"}, {22'b0, out_cnt}, n);
`endif
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({tag, "_hold_valid"}, {31'b0, out_valid}, 1);
      chk({tag, "_hold_data"}, $signed(out_data), s);
      chk({tag, "_hold_ready"}, {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_drop_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_kept_data"}, $signed(out_data), s);
    chk({tag, "_back_ready"}, {31'b0, in_ready}, 1);
  endtask

  initial begin
    #3;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data", $signed(out_data), 0);
    chk("rst_sat", {31'b0, out_sat}, 0);
    chk("rst_ready", {31'b0, in_ready}, 0);
    #14 rst_n = 1'b1;
    chk("rst_release_ready", {31'b0, in_ready}, 0);
    tick();
    chk("first_edge_ready", {31'b0, in_ready}, 1);
    pkt = '{3};
    run_pkt("single3", 0);
    pkt = '{7, 7, -7};
    run_pkt("p77m7", 0);
    pkt = '{-5, -4, 2};
    run_pkt("m5m4p2", 0);
    pkt = '{-8, 0};
    run_pkt("neg8", 0);
    for (int a = -7; a <= 7; a++)
      for (int b = -7; b <= 7; b++) begin
        pkt = '{a, b};
        run_pkt($sformatf("pair_%0d_%0d", a, b), 0);
      end
    pkt = '{-6, -7};
    run_pkt("stall", 5);
    pkt = '{1, 1};
    run_pkt("after_stall", 0);
    beat(4, 0);
    beat(2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_data", $signed(out_data), 0);
    chk("midrst_sat", {31'b0, out_sat}, 0);
    chk("midrst_ready", {31'b0, in_ready}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    pkt = '{1};
    run_pkt("after_rst", 0);
    for (int r = 0; r < 200; r++) begin
      int len = int'($urandom_range(1, 6));
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(int'($urandom_range(0, 15)) - 8);
      run_pkt($sformatf("rand%0d", r), int'($urandom_range(0, 2)));
    end
    pkt = {};
    for (int i = 0; i < 1030; i++) pkt.push_back(int'($urandom_range(0, 15)) - 8);
    run_pkt("long", 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sat_acc_stream.md
Name: sat_acc_stream

Overview:
- Streaming saturating accumulator for the inference engine's fixed-point datapath.
- Consumes a stream of signed W-bit operands over a valid/ready handshake.
- Sums them one per cycle with the symmetric saturation rule used by the combinational saturating adder (range ±(2^(W-1)-1)).
- Emits one result per packet (terminated by in_last) over a second valid/ready handshake toward the neuron activation stage.

Parameters:
- W, 4, operand/result width in bits (signed two's complement); legal range is ±(2^(W-1)-1), so ±7 at W=4.
- CNT_W, 10, width of the internal beat counter (supports packets up to 2^CNT_W-1 beats; 784-pixel rows fit).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  W  signed operand
- in_last  in  1  marks final beat of packet
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  W  signed saturated packet sum
- out_sat  out  1  at least one clamp occurred in this packet

Behaviour:
- Reset: async on rst_n low. out_valid=0, out_data=0, out_sat=0, in_ready=0 while rst_n low. Internal acc=0, cnt=0, state=ACC. in_ready=1 from the first clk edge after release.
- MAX = 2^(W-1)-1 (7 at W=4). MIN = -MAX (-7).
- Input sanitise: in_data equal to -2^(W-1) (0x8 at W=4) is treated as MIN and sets sticky sat.
- Beat transfer: a beat transfers when in_valid && in_ready at a rising edge.
- Per-beat update: acc_next = clamp(acc + x, MIN, MAX), where x is the sanitised in_data. The sum is computed in W+1 bits before clamping. Any clamp sets sticky sat.
- Saturation is applied per beat, not once at the end. Example: +7, +7, -7 gives 0 (7, then 7, then 0), not 7.
- ACC state: in_ready=1. On a beat with in_last=0: acc, sat and cnt update.
- ACC state, beat with in_last=1:
  - out_data <= acc_next, out_sat <= sat_next, out_valid <= 1.
  - acc, sat and cnt clear to 0.
  - Go to HOLD.
- Latency: result is visible the cycle after the last beat transfers.
- HOLD state: in_ready=0. out_data, out_sat and out_valid stay stable until out_ready=1 at an edge.
  - On that edge: out_valid <= 0 and state goes to ACC.
  - out_data and out_sat keep their last values after the handshake.
- No bypass: a result-accept edge and a new input beat never occur together, since in_ready=0 in HOLD.
- Single-beat packet (in_last on the first beat): result = sanitised operand.
- Counter wrap: cnt saturates at 2^CNT_W-1 and does not wrap. Accumulation continues unaffected.
- Idle cycles (in_valid=0) mid-packet: state is held, no change.
- Reset mid-packet or in HOLD: partial sum is discarded and the block returns to reset values immediately (async).
- out_valid never drops without an out_ready handshake, except on reset.

Optional Feature:
- Macro: SAT_ACC_CNT_EN.
- When defined:
  - Adds output port out_cnt [CNT_W-1:0], the number of beats in the packet (saturating at 2^CNT_W-1).
  - out_cnt is captured with out_data and held under the same HOLD rules.
  - Reset value is 0.
- When undefined: port absent, cnt register removed, all other behaviour identical.

Test Plan:
- Reset then single beat 3 with in_last, out_ready=1 -> out_valid for exactly 1 cycle, out_data=3, out_sat=0; with SAT_ACC_CNT_EN, out_cnt=1.
- Packet +7,+7,-7 (last) -> out_data=0, out_sat=1. Packet -5,-4,+2 (last) -> out_data=-5, out_sat=1.
- Exhaustive pairs a,b in -7..7 as 2-beat packets -> out_data = clamp(a+b,-7,7), out_sat=1 exactly when a+b is outside ±7; matches the combinational adder model.
- Operand 0x8 (-8) then 0 (last) -> out_data=-7, out_sat=1.
- Result with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout. A following packet 1,1 (last) after release -> out_data=2, no carry-over from the previous packet.
- rst_n pulsed low mid-packet after beats 4,2 -> outputs immediately 0. Next packet 1 (last) -> out_data=1.
